// File: rtl/cnn_pkg.sv
// ============================================================================
// Module  : cnn_pkg
// Brief   : Shared CNN datapath constants and conv FSM state encoding.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

    localparam int IMG_W  = 28;
    localparam int OUT_W  = 26;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int BIAS_W = 16;
    localparam int ACC_W  = 20;
    localparam int ADDR_W = 10;
    localparam int N_TAPS = 9;
    localparam int RC_W   = 5;
    localparam int PROD_W = DATA_W + 1 + COEF_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } conv_state_t;

endpackage

`default_nettype wire

// File: rtl/conv_mac.sv
// ============================================================================
// Module  : conv_mac
// Brief   : Signed MAC with clear, plus bias/shift/ReLU/saturate output path.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module conv_mac
    import cnn_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_pix,
    input  logic [COEF_W-1:0] i_coef,
    input  logic [BIAS_W-1:0] i_bias,
    output logic [DATA_W-1:0] o_pix
);

    localparam int SUM_W = ACC_W + 1;

    logic signed [PROD_W-1:0] w_pix_x;
    logic signed [PROD_W-1:0] w_coef_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [SUM_W-1:0]  w_shift;

    // Pixel is unsigned, so it is zero-extended before the signed multiply.
    assign w_pix_x  = {{(PROD_W-DATA_W){1'b0}}, i_pix};
    assign w_coef_x = {{(PROD_W-COEF_W){i_coef[COEF_W-1]}}, i_coef};
    assign w_prod   = w_pix_x * w_coef_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
        end
    end

    assign w_sum   = {r_acc[ACC_W-1], r_acc}
                   + {{(SUM_W-BIAS_W){i_bias[BIAS_W-1]}}, i_bias};
    assign w_shift = w_sum >>> SHIFT;

    always_comb begin
        o_pix = w_shift[DATA_W-1:0];
        if (w_shift[SUM_W-1]) begin
            o_pix = '0;
        end else if (|w_shift[SUM_W-2:DATA_W]) begin
            o_pix = '1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/conv3x3_relu.sv
// ============================================================================
// Module  : conv3x3_relu
// Brief   : 3x3 valid convolution + requant/ReLU over a 28x28 BRAM image.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module conv3x3_relu
    import cnn_pkg::*;
#(
    parameter int SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [N_TAPS*COEF_W-1:0] weights,
    input  logic [BIAS_W-1:0]        bias,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        rd_data,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_W-1:0] c_ROW_STEP  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] c_WRAP_STEP = ADDR_W'(IMG_W - OUT_W + 1);
    localparam logic [RC_W-1:0]   c_LAST_RC   = RC_W'(OUT_W - 1);

    conv_state_t         r_state;
    logic [3:0]          r_k;
    logic [1:0]          r_kc;
    logic [RC_W-1:0]     r_row;
    logic [RC_W-1:0]     r_col;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_oaddr;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_busy;
    logic                r_done;

    logic [COEF_W-1:0]   w_coef_arr [N_TAPS];
    logic [3:0]          w_tap;
    logic                w_start_ok;
    logic                w_mac_en;
    logic                w_mac_clr;
    logic [DATA_W-1:0]   w_pix;

    for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_taps
        assign w_coef_arr[gi] = weights[gi*COEF_W +: COEF_W];
    end

    // A start landing in the same cycle as done is dropped.
    assign w_start_ok = (r_state == ST_IDLE) && start && !r_done;

    // rd_data lags the address by one cycle, so the tap used is k-1.
    assign w_tap     = (r_state == ST_DRAIN) ? 4'd8 :
                       (r_k == 4'd0)         ? 4'd0 : r_k - 4'd1;
    assign w_mac_en  = ((r_state == ST_READ) && (r_k != 4'd0)) || (r_state == ST_DRAIN);
    assign w_mac_clr = w_start_ok || (r_state == ST_WRITE);

    conv_mac #(
        .SHIFT (SHIFT)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_mac_clr),
        .i_en   (w_mac_en),
        .i_pix  (rd_data),
        .i_coef (w_coef_arr[w_tap]),
        .i_bias (bias),
        .o_pix  (w_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_kc      <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_base    <= '0;
            r_oaddr   <= '0;
            r_rd_addr <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state   <= ST_READ;
                        r_k       <= '0;
                        r_kc      <= '0;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_base    <= '0;
                        r_oaddr   <= '0;
                        r_rd_addr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (r_k == 4'd8) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_k <= r_k + 4'd1;
                        if (r_kc == 2'd2) begin
                            r_kc      <= '0;
                            r_rd_addr <= r_rd_addr + c_ROW_STEP;
                        end else begin
                            r_kc      <= r_kc + 2'd1;
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_oaddr;
                    r_wr_data <= w_pix;
                    r_k       <= '0;
                    r_kc      <= '0;
                    if ((r_row == c_LAST_RC) && (r_col == c_LAST_RC)) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_state <= ST_READ;
                        r_oaddr <= r_oaddr + 1'b1;
                        // Column wrap: base jumps past the two unused border columns.
                        if (r_col == c_LAST_RC) begin
                            r_col     <= '0;
                            r_row     <= r_row + 1'b1;
                            r_base    <= r_base + c_WRAP_STEP;
                            r_rd_addr <= r_base + c_WRAP_STEP;
                        end else begin
                            r_col     <= r_col + 1'b1;
                            r_base    <= r_base + 1'b1;
                            r_rd_addr <= r_base + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_addr = r_rd_addr;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_conv3x3_relu.sv
// ============================================================================
// Module  : tb_conv3x3_relu
// Brief   : Scoreboard bench for conv3x3_relu against an arithmetic reference.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_conv3x3_relu;
    import cnn_pkg::*;

    localparam int TB_SHIFT = 4;
    localparam int NPIX     = OUT_W * OUT_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [71:0] weights = '0;
    logic [15:0] bias = '0;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data = '0;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    logic [7:0]  img     [IMG_W*IMG_W];
    logic [7:0]  out_mem [NPIX];

    typedef struct {
        int addr;
        int data;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int start_cyc = 0;
    int run_base = 0;
    int wr_total = 0;
    int last_wr_cyc = 0;
    int done_total = 0;
    int exp_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (int'(rd_addr) < IMG_W*IMG_W) rd_data <= img[rd_addr];
        else                             rd_data <= 8'h00;
    end

    conv3x3_relu #(.SHIFT(TB_SHIFT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .weights (weights),
        .bias    (bias),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    // Reference: direct 3x3 dot product, bias, arithmetic shift, clamp to 0..255.
    function automatic int ref_px(input int r, input int c);
        int s;
        logic signed [7:0] wk;
        s = 0;
        for (int kr = 0; kr < 3; kr++) begin
            for (int kc = 0; kc < 3; kc++) begin
                wk = weights[(kr*3+kc)*8 +: 8];
                s += int'(img[(r+kr)*IMG_W + c + kc]) * int'(wk);
            end
        end
        s = s + int'($signed(bias));
        s = s >>> TB_SHIFT;
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Monitor: pops the scoreboard on every write and checks write/done timing.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write", wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                if (int'(wr_addr) != e.addr || int'(wr_data) != e.data) begin
                    miscompares++;
                    $display("FAIL wr_pixel: got addr %0d data %0d, expected addr %0d data %0d",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
            exp_cyc = (wr_total == run_base) ? start_cyc + 11 : last_wr_cyc + 11;
            vectors++;
            if (cyc != exp_cyc) begin
                miscompares++;
                $display("FAIL wr_timing: write at cycle %0d, expected cycle %0d", cyc, exp_cyc);
            end
            if (int'(wr_addr) < NPIX) out_mem[wr_addr] = wr_data;
            last_wr_cyc = cyc;
            wr_total++;
        end
        if (rst_n && done) begin
            vectors++;
            if (cyc != last_wr_cyc + 1 || wr_total - run_base != NPIX) begin
                miscompares++;
                $display("FAIL done_timing: done at cycle %0d after %0d writes, expected cycle %0d after %0d",
                         cyc, wr_total - run_base, last_wr_cyc + 1, NPIX);
            end
            done_total++;
        end
    end

    task automatic fill_img(input int mode, input int val);
        for (int i = 0; i < IMG_W*IMG_W; i++) begin
            case (mode)
                0:       img[i] = 8'(val);
                1:       img[i] = 8'(i % 256);
                default: img[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic set_w(input int mode, input int val);
        for (int k = 0; k < 9; k++) begin
            if (mode == 0)      weights[k*8 +: 8] = 8'(val);
            else if (mode == 1) weights[k*8 +: 8] = (k == 4) ? 8'(val) : 8'h00;
            else                weights[k*8 +: 8] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic run_map(input bit mid_start, input bit coincide, input bit abort);
        int  d0;
        bit  seen;
        sb.delete();
        for (int r = 0; r < OUT_W; r++)
            for (int c = 0; c < OUT_W; c++)
                sb.push_back('{r*OUT_W + c, ref_px(r, c)});
        @(negedge clk);
        start    = 1'b1;
        run_base = wr_total;
        d0       = done_total;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start     = 1'b0;
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        seen = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (abort && (wr_total - run_base >= 100)) begin
                rst_n = 1'b0;
                #1;
                chk("reset_wr_en", int'(wr_en), 0);
                chk("reset_busy", int'(busy), 0);
                chk("reset_done", int'(done), 0);
                sb.delete();
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (mid_start) start = (i == 500);
            if (done) begin
                seen = 1'b1;
                if (coincide) start = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: no done within 8000 cycles, expected done");
        end
        if (coincide) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        repeat (15) @(negedge clk);
        chk("idle_after_done", int'(busy), 0);
        chk("done_count", done_total - d0, 1);
        chk("all_written", sb.size(), 0);
    endtask

    initial begin
        int pool_exp;
        int pool_got;

        #2;
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        fill_img(0, 16);  set_w(0, 1);   bias = 16'd0;   run_map(0, 1, 0);
        fill_img(1, 0);   set_w(1, 16);  bias = 16'd0;   run_map(0, 0, 0);
        fill_img(0, 255); set_w(0, 1);   bias = 16'd0;   run_map(0, 0, 0);
        fill_img(0, 255); set_w(0, 2);   bias = 16'd0;   run_map(0, 0, 0);
        fill_img(2, 0);   set_w(0, 255); bias = 16'd100; run_map(0, 0, 0);
        fill_img(2, 0);   set_w(0, 0);   bias = 16'd80;  run_map(0, 0, 0);

        fill_img(2, 0); set_w(2, 0);
        bias = 16'($urandom_range(0, 4095) - 2048);
        run_map(1, 0, 0);

        fill_img(2, 0); set_w(2, 0);
        bias = 16'($urandom_range(0, 4095) - 2048);
        run_map(0, 0, 1);
        run_map(0, 1, 0);

        pool_exp = ref_px(0, 0);
        if (ref_px(0, 1) > pool_exp) pool_exp = ref_px(0, 1);
        if (ref_px(1, 0) > pool_exp) pool_exp = ref_px(1, 0);
        if (ref_px(1, 1) > pool_exp) pool_exp = ref_px(1, 1);
        pool_got = int'(out_mem[0]);
        if (int'(out_mem[1])  > pool_got) pool_got = int'(out_mem[1]);
        if (int'(out_mem[26]) > pool_got) pool_got = int'(out_mem[26]);
        if (int'(out_mem[27]) > pool_got) pool_got = int'(out_mem[27]);
        chk("pool_window_00", pool_got, pool_exp);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv3x3_relu.md
Name: conv3x3_relu

Overview:
Single-channel 3x3 convolution stage. Reads a 28x28 unsigned 8-bit image from a 1-cycle-latency BRAM port and computes each output with signed weights plus bias, followed by shift requantisation and ReLU. It writes the 26x26 feature map row-major to the BRAM that max_pool reads, at addresses 0..675. It sits directly upstream of max_pool, and its `done` is what the top-level sequencer uses to pulse max_pool's `start`.

Parameters:
- IMG_W, 28, input image width/height (square)
- OUT_W, 26, output width/height (IMG_W-2)
- DATA_W, 8, pixel width, unsigned
- COEF_W, 8, weight width, signed two's complement
- BIAS_W, 16, bias width, signed
- ACC_W, 20, accumulator width, signed
- SHIFT, 4, arithmetic right shift applied before ReLU
- ADDR_W, 10, read/write address width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start pulse, ignored while busy
- weights  in  9*COEF_W  kernel, w[k] at bits [k*COEF_W +: COEF_W], k=kr*3+kc; must be held stable while busy
- bias  in  BIAS_W  signed bias; must be held stable while busy
- rd_addr  out  ADDR_W  input BRAM read address
- rd_data  in  DATA_W  BRAM data for the address presented on the previous cycle
- wr_en  out  1  output BRAM write strobe
- wr_addr  out  ADDR_W  output BRAM write address
- wr_data  out  DATA_W  output pixel
- busy  out  1  high from the cycle after start to done
- done  out  1  one-cycle pulse after the final write

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - row, col, k and the accumulator clear to 0.
  - rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
- FSM states: IDLE, READ, DRAIN, WRITE, FIN.
- IDLE: on start=1, go to READ with row=col=k=0 and accumulator=0.
- READ, 9 cycles, k=0..8:
  - rd_addr = base + (k/3)*IMG_W + (k%3), where base = row*IMG_W + col is kept as an incremental counter (no multiplier).
  - When k>=1, accumulate rd_data * w[k-1].
  - After k=8, go to DRAIN.
- DRAIN, 1 cycle: accumulate rd_data * w[8], then go to WRITE.
- WRITE, 1 cycle:
  - wr_en=1, wr_addr = row*OUT_W + col, also kept as a counter.
  - wr_data = clamp(relu((acc + sext(bias)) >>> SHIFT), 0, 255).
  - If the last pixel was just written, go to FIN. Otherwise advance col; on col wrap, reset col to 0 and increment row. Clear the accumulator and return to READ.
- FIN, 1 cycle: done=1, busy=0 next cycle, return to IDLE.
- Arithmetic widths:
  - Pixel is zero-extended to DATA_W+1 bits signed; product is 17 bits signed.
  - ACC_W=20 covers the worst case 9*255*128 with no overflow.
  - Bias is sign-extended to ACC_W+1 bits before the add.
- Timing: 11 cycles per pixel, 676*11 = 7436 cycles from the first READ cycle to the last WRITE, then done on the next cycle.
- wr_en is asserted only in WRITE and is never asserted in any two consecutive cycles.
- wr_* outputs are driven from registers only; there is no combinational path from rd_data to wr_*.
- Boundary conditions:
  - start while busy: ignored.
  - start coincident with done: ignored. A new start is accepted only in IDLE.
  - Reset mid-run: takes effect immediately. No further writes, no done pulse. A later start recomputes the full map from pixel 0.
  - Sum exactly 0 or negative after shift: output 0. Shifted sum > 255: output 255.

Decomposition:
- Shared package cnn_pkg holds:
  - IMG_W, OUT_W, DATA_W, COEF_W, ACC_W, ADDR_W constants, shared with max_pool (26 = its input width).
  - The conv FSM state encoding.
- One natural sub-module: conv_mac, containing the signed multiply-accumulate, the clear, and the requant/ReLU/saturate path.
- Address counters and the FSM stay in conv3x3_relu.

Test Plan:
- Image all 16, weights all 1, bias 0, SHIFT 0: 676 writes, every wr_data=144; wr_addr ascending 0..675 with no gaps or repeats.
- Image pixel(r,c) = (r*IMG_W+c) mod 256, identity kernel (w[4]=16, others 0), bias 0, SHIFT 4: wr_data at (r,c) equals pixel(r+1,c+1), e.g. output addr 0 = 29, output addr 26 = 57.
- Image all 255, weights all 1, SHIFT 4, bias 0: 2295>>>4 = 143 everywhere. Same with SHIFT 0: saturates to 255 everywhere.
- Weights all -1, any image, bias 100: all outputs 0 (ReLU). Weights all 0, bias 80, SHIFT 4: all outputs 5.
- Timing: start at cycle T. The first wr_en occurs 11 cycles after the first READ cycle, with successive wr_en pulses 11 cycles apart. done pulses exactly once, one cycle after the 676th write. A second start pulse mid-run produces no extra writes.
- Reset mid-run: drop rst_n during pixel 100. wr_en, busy and done go low immediately. Release rst_n and start again: a full 676-write map matches the reference model. Then chain into max_pool and check its output at window (0,0).
